seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode hex display.
- Holds the 32-bit display value and a control word written over a simple valid/ready register port.
- Drives one shared 8-bit segment bus plus 8 active-low digit enables, one digit at a time.
- Display contents change only at frame boundaries, so a frame is never torn.

Parameters:
- CLK_DIV, 1000: clock cycles per digit slot; legal range is 2 or more.
- DEAD, 1: cycles at the start of each slot with all digits off (anti-ghosting); legal range is 0 to CLK_DIV-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- wr_valid  input  1  register write request
- wr_ready  output  1  write accepted when wr_valid and wr_ready are both high
- wr_addr  input  1  0 = DATA register, 1 = CTRL register
- wr_data  input  32  write data
- seg_out  output  8  shared segment bus, active-low; bit7..bit1 = a..g, bit0 = dp
- an_out  output  8  digit enables, active-low; bit i selects digit i (digit 0 = nibble [3:0])
- frame_done  output  1  one-cycle pulse when digit 7's slot ends

Behaviour:
- Reset values:
  - seg_out = 8'hFF, an_out = 8'hFF, frame_done = 0, wr_ready = 0.
  - Shadow and active DATA = 0.
  - Shadow and active CTRL = 0 (display disabled).
  - Slot counter = 0, digit index = 0.
- wr_ready is 1 in every cycle after reset deasserts; writes have no backpressure otherwise.
- An accepted write updates the shadow register selected by wr_addr on the next clock edge.
- CTRL fields:
  - bit0 EN: scanning enabled.
  - bit1 LZS: leading-zero suppression.
  - bits[15:8] BLANK: per-digit force-off mask.
  - Other bits are ignored and not stored.
- Slot counter counts 0..CLK_DIV-1 and then wraps to 0.
  - On the wrap, the digit index advances mod 8.
  - When the index moves 7 -> 0, frame_done pulses for 1 cycle.
  - In the same cycle, active DATA and CTRL load from shadow.
- Simultaneous write and frame boundary: the value being written in that same cycle is the one that reaches active (bypass). It is visible from the first cycle of the new frame.
- When active EN = 0:
  - The counters keep running and frame_done keeps pulsing.
  - an_out = 8'hFF and seg_out = 8'hFF.
  - Active still reloads at each frame boundary, so setting EN takes effect at the next boundary.
- When EN = 1, for the slot of digit i:
  - Slot count < DEAD: an_out = 8'hFF and seg_out = 8'hFF.
  - Otherwise: an_out = ~(1 << i) and seg_out = code of active nibble i. The digit is instead kept off (an_out bit i high) if BLANK[i] = 1 or digit i is suppressed.
- Leading-zero suppression (LZS = 1):
  - Digit i (i >= 1) is suppressed iff active nibbles 7..i are all zero.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Segment codes (hex digit: code):
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:09, A:11, B:C1, C:63, D:85, E:61, F:71
- seg_out and an_out are registered: one cycle of latency from the counter and digit state. At most one an_out bit is low in any cycle.
- Reset mid-frame: on the next edge every output and register returns to its reset value, and scanning restarts at digit 0 with slot count 0.
- Implementation size: about 150-250 lines of RTL (counters, shadow/active registers, suppression logic, decoder).

Test Plan:
- Reset check: CLK_DIV=4, DEAD=1. Hold rst for 3 cycles, then release -> seg_out=FF, an_out=FF, wr_ready=0 during reset; wr_ready=1 on the first cycle after release.
- Basic scan: write DATA=32'h89ABCDEF and CTRL=1 in frame 0 -> from frame 1 onward each slot shows 1 cycle with all digits off, then 3 cycles of:
  - an_out=FE with seg_out=71 (digit 0)
  - an_out=FD with seg_out=61 (digit 1)
  - … through an_out=7F with seg_out=01 (digit 7)
  - frame_done pulses every 32 cycles.
- Tear-free update: write DATA=32'h11111111 while digit 3 is displayed -> digits 4..7 of the current frame still show old nibbles; new values appear only after the frame_done pulse.
- Boundary bypass: issue the write in exactly the cycle where frame_done=1 -> the new value is shown on digit 0 of the immediately following frame.
- Suppression and blank: DATA=32'h00000A05, CTRL=32'h0000_2003 (LZS=1, EN=1, BLANK[5]=1) -> digits 0..2 show 49, 03, 11; digits 3..7 have an_out held high. Then DATA=0 with CTRL=3 -> only digit 0 lights, with seg_out=03.
- Disable and mid-frame reset: set CTRL=0 -> an_out stays FF while frame_done keeps pulsing. Re-enable, then assert rst during digit 5 -> all outputs return to FF/0, and scanning restarts at digit 0 only after EN is written again.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit common-anode hex display scan controller
// Shadow registers are copied to active only at frame boundaries, so a frame is never torn.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 1000,
  parameter int DEAD    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_addr,
  input  logic [31:0] wr_data,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  output logic        frame_done
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   sh_data_q, sh_data_d;
  logic [31:0]   act_data_q, act_data_d;
  // Control is stored as {BLANK[7:0], LZS, EN}
  logic [9:0]    sh_ctrl_q, sh_ctrl_d;
  logic [9:0]    act_ctrl_q, act_ctrl_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic          wr_fire;
  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nib;
  logic [7:0]    zero_from;
  logic          suppressed;

  function automatic logic [7:0] seg_code(input logic [3:0] n);
    case (n)
      4'h0:    seg_code = 8'h03;
      4'h1:    seg_code = 8'h9F;
      4'h2:    seg_code = 8'h25;
      4'h3:    seg_code = 8'h0D;
      4'h4:    seg_code = 8'h99;
      4'h5:    seg_code = 8'h49;
      4'h6:    seg_code = 8'h41;
      4'h7:    seg_code = 8'h1F;
      4'h8:    seg_code = 8'h01;
      4'h9:    seg_code = 8'h09;
      4'hA:    seg_code = 8'h11;
      4'hB:    seg_code = 8'hC1;
      4'hC:    seg_code = 8'h63;
      4'hD:    seg_code = 8'h85;
      4'hE:    seg_code = 8'h61;
      default: seg_code = 8'h71;
    endcase
  endfunction

  assign wr_ready   = ~rst;
  assign wr_fire    = wr_valid & wr_ready;
  assign slot_end   = (cnt_q == CNT_MAX);
  assign frame_end  = slot_end && (idx_q == 3'd7);
  assign nib        = act_data_q[{idx_q, 2'b00} +: 4];

  // zero_from[i] is set when nibbles 7..i of the active value are all zero
  always_comb begin
    zero_from    = '0;
    zero_from[7] = (act_data_q[31:28] == 4'h0);
    for (int i = 6; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (act_data_q[4*i +: 4] == 4'h0);
    end
  end

  assign suppressed = act_ctrl_q[1] && (idx_q != 3'd0) && zero_from[idx_q];

  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    idx_d      = slot_end ? idx_q + 3'd1 : idx_q;
    sh_data_d  = sh_data_q;
    sh_ctrl_d  = sh_ctrl_q;
    if (wr_fire && !wr_addr) sh_data_d = wr_data;
    if (wr_fire &&  wr_addr) sh_ctrl_d = {wr_data[15:8], wr_data[1:0]};
    // Loading from the _d side lets a write in the boundary cycle land in this frame
    act_data_d = frame_end ? sh_data_d : act_data_q;
    act_ctrl_d = frame_end ? sh_ctrl_d : act_ctrl_q;
    fd_d       = (cnt_d == CNT_MAX) && (idx_d == 3'd7);
    seg_d      = 8'hFF;
    an_d       = 8'hFF;
    if (act_ctrl_q[0] && (cnt_q >= DEAD_CNT)) begin
      seg_d = seg_code(nib);
      if (!act_ctrl_q[2 + idx_q] && !suppressed) an_d = ~(8'b1 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      act_data_q <= '0;
      sh_ctrl_q  <= '0;
      act_ctrl_q <= '0;
      seg_q      <= 8'hFF;
      an_q       <= 8'hFF;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      act_data_q <= act_data_d;
      sh_ctrl_q  <= sh_ctrl_d;
      act_ctrl_q <= act_ctrl_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
// Reference model tracks time since reset and derives slot/digit arithmetically.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEAD    = 1;
  localparam int FRAME   = 8 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_addr = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic        frame_done;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          t = 0;
  logic [31:0] m_sh_data = '0, m_sh_ctrl = '0, m_act_data = '0, m_act_ctrl = '0;
  logic [7:0]  exp_an = 8'hFF, exp_seg = 8'hFF;
  logic        exp_fd = 1'b0;
  logic [7:0]  code_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  logic [7:0]  old_tab [8] = '{8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01};
  logic [7:0]  sup_tab [3] = '{8'h49, 8'h03, 8'h11};

  // Advance one clock and update the model so exp_* describe the new cycle
  task automatic tick();
    logic       fire;
    int         cnt, dig;
    logic [3:0] n;
    logic       lit;
    fire = wr_valid && !rst;
    @(posedge clk);
    if (rst) begin
      t = 0;
      m_sh_data = '0; m_sh_ctrl = '0; m_act_data = '0; m_act_ctrl = '0;
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_fd = 1'b0;
    end else begin
      cnt = t % CLK_DIV;
      dig = (t / CLK_DIV) % 8;
      n   = 4'(m_act_data >> (4 * dig));
      lit = !m_act_ctrl[8 + dig] && !(m_act_ctrl[1] && dig != 0 && (m_act_data >> (4 * dig)) == 0);
      if (!m_act_ctrl[0] || cnt < DEAD) begin
        exp_an = 8'hFF; exp_seg = 8'hFF;
      end else begin
        exp_seg = code_tab[n];
        exp_an  = lit ? ~(8'd1 << dig) : 8'hFF;
      end
      if (fire) begin
        if (wr_addr) m_sh_ctrl = wr_data;
        else         m_sh_data = wr_data;
      end
      if (t % FRAME == FRAME - 1) begin
        m_act_data = m_sh_data;
        m_act_ctrl = m_sh_ctrl;
      end
      t++;
      exp_fd = (t % FRAME == FRAME - 1);
    end
    #1;
  endtask

  task automatic do_write(input logic a, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    for (int i = 0; i < 2 * FRAME && !exp_fd; i++) tick();
    checks++;
    if (frame_done !== 1'b1 || !exp_fd) begin
      errors++;
      $display("FAIL %s_wait_fd frame_done=%b required 1", name, frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if ({seg_out, an_out, frame_done, wr_ready} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset seg=%h an=%h fd=%b rdy=%b required FF FF 0 0", seg_out, an_out, frame_done, wr_ready);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", wr_ready);
    end
  endtask

  task automatic test_basic_scan();
    int pos, d, c, pulses;
    do_write(1'b0, 32'h89ABCDEF);
    do_write(1'b1, 32'h1);
    wait_fd("basic");
    tick();
    pulses = 0;
    repeat (FRAME) begin
      tick();
      pos = (t - 1) % FRAME; d = pos / CLK_DIV; c = pos % CLK_DIV;
      pulses += int'(frame_done);
      checks++;
      if ({an_out, seg_out, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL basic_model t=%0d an=%h/%h seg=%h/%h fd=%b/%b", t, an_out, exp_an, seg_out, exp_seg, frame_done, exp_fd);
      end
      checks++;
      if (c == 0 ? (an_out !== 8'hFF || seg_out !== 8'hFF)
                 : (an_out !== ~(8'd1 << d) || seg_out !== old_tab[d])) begin
        errors++;
        $display("FAIL basic_const digit=%0d slot=%0d an=%h seg=%h", d, c, an_out, seg_out);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL basic_fd_count got %0d required 1", pulses);
    end
  endtask

  task automatic test_tear_free();
    int d;
    for (int i = 0; i < 2 * FRAME && ((t / CLK_DIV) % 8) != 3; i++) tick();
    do_write(1'b0, 32'h11111111);
    for (int i = 0; i < 2 * FRAME && !exp_fd; i++) begin
      tick();
      d = ((t - 1) % FRAME) / CLK_DIV;
      checks++;
      if (an_out !== 8'hFF && seg_out !== old_tab[d]) begin
        errors++;
        $display("FAIL tear_old digit=%0d seg=%h required %h", d, seg_out, old_tab[d]);
      end
    end
    tick();
    repeat (FRAME) begin
      tick();
      checks++;
      if (an_out !== exp_an || (an_out !== 8'hFF && seg_out !== 8'h9F)) begin
        errors++;
        $display("FAIL tear_new t=%0d an=%h/%h seg=%h required 9F", t, an_out, exp_an, seg_out);
      end
    end
  endtask

  task automatic test_bypass();
    wait_fd("bypass");
    do_write(1'b0, 32'h76543210);
    repeat (2) begin
      tick();
      checks++;
      if ({an_out, seg_out} !== {exp_an, exp_seg}) begin
        errors++;
        $display("FAIL bypass_model t=%0d an=%h/%h seg=%h/%h", t, an_out, exp_an, seg_out, exp_seg);
      end
    end
    checks++;
    if (an_out !== 8'hFE || seg_out !== 8'h03) begin
      errors++;
      $display("FAIL bypass_digit0 an=%h seg=%h required FE 03", an_out, seg_out);
    end
  endtask

  task automatic test_suppress();
    int pos, d, c;
    do_write(1'b0, 32'h00000A05);
    do_write(1'b1, 32'h00002003);
    wait_fd("suppress");
    tick();
    repeat (FRAME) begin
      tick();
      pos = (t - 1) % FRAME; d = pos / CLK_DIV; c = pos % CLK_DIV;
      checks++;
      if (c != 0 && d < 3 ? (an_out !== ~(8'd1 << d) || seg_out !== sup_tab[d]) : an_out !== 8'hFF) begin
        errors++;
        $display("FAIL suppress_blank digit=%0d slot=%0d an=%h seg=%h", d, c, an_out, seg_out);
      end
    end
    do_write(1'b0, 32'h0);
    do_write(1'b1, 32'h3);
    wait_fd("zero");
    tick();
    repeat (FRAME) begin
      tick();
      pos = (t - 1) % FRAME; d = pos / CLK_DIV; c = pos % CLK_DIV;
      checks++;
      if (c != 0 && d == 0 ? (an_out !== 8'hFE || seg_out !== 8'h03) : an_out !== 8'hFF) begin
        errors++;
        $display("FAIL suppress_zero digit=%0d slot=%0d an=%h seg=%h", d, c, an_out, seg_out);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    repeat (12 * FRAME) begin
      if ($urandom_range(0, 7) == 0) begin
        wr_valid = 1'b1;
        wr_addr  = 1'($urandom);
        d        = $urandom;
        wr_data  = wr_addr ? {d[31:2], d[1], (d[0] | (d[7:4] != 0))}
                           : d >> (4 * $urandom_range(0, 7));
      end else begin
        wr_valid = 1'b0;
      end
      tick();
      checks++;
      if ({an_out, seg_out, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL random t=%0d an=%h/%h seg=%h/%h fd=%b/%b", t, an_out, exp_an, seg_out, exp_seg, frame_done, exp_fd);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_disable_reset();
    int pulses;
    do_write(1'b1, 32'h0);
    wait_fd("disable");
    tick();
    pulses = 0;
    repeat (2 * FRAME) begin
      tick();
      pulses += int'(frame_done);
      checks++;
      if (an_out !== 8'hFF || seg_out !== 8'hFF) begin
        errors++;
        $display("FAIL disable_dark an=%h seg=%h required FF FF", an_out, seg_out);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL disable_fd_count got %0d required 2", pulses);
    end
    do_write(1'b0, 32'h01234567);
    do_write(1'b1, 32'h1);
    wait_fd("reenable");
    for (int i = 0; i < 2 * FRAME && (((t - 1) / CLK_DIV) % 8 != 5 || an_out === 8'hFF); i++) tick();
    checks++;
    if (an_out !== 8'hDF) begin
      errors++;
      $display("FAIL reenable_digit5 an=%h required DF", an_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({seg_out, an_out, frame_done, wr_ready} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset seg=%h an=%h fd=%b rdy=%b required FF FF 0 0", seg_out, an_out, frame_done, wr_ready);
    end
    rst = 1'b0;
    repeat (2 * FRAME) begin
      tick();
      checks++;
      if (an_out !== 8'hFF || {seg_out, frame_done} !== {exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL postreset_dark t=%0d an=%h seg=%h fd=%b/%b", t, an_out, seg_out, frame_done, exp_fd);
      end
    end
    do_write(1'b1, 32'h1);
    repeat (2 * FRAME) begin
      tick();
      checks++;
      if ({an_out, seg_out, frame_done} !== {exp_an, exp_seg, exp_fd}) begin
        errors++;
        $display("FAIL restart t=%0d an=%h/%h seg=%h/%h fd=%b/%b", t, an_out, exp_an, seg_out, exp_seg, frame_done, exp_fd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_bypass();
    test_suppress();
    test_random();
    test_disable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
